regfile_write_bank: RTL
=======================

Name: regfile_write_bank

Overview:
- Write side and storage of the 32-entry register file.
- Decodes a 5-bit write address into one of 32 N-bit registers and holds all of them.
- Presents all 32 values on one flat bus that feeds the existing 32-to-1 read-select muxes.
- Adds a write handshake and a sequenced clear-all operation: 32 cycles with a sweep counter, used on pipeline flush/restart.

Parameters:
- N, 32, width of each register entry in bits.
- ZERO_R0, 1, when 1 entry 0 is hardwired to zero and writes to address 0 are discarded; when 0 entry 0 is an ordinary register.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- WrEn  input  1  write request, valid for the current cycle.
- WrAddr  input  5  target entry 0..31.
- WrData  input  N  data to store.
- WrReady  output  1  write accepted this cycle when WrEn=1.
- ClrReq  input  1  single-cycle pulse requesting clear-all.
- Busy  output  1  clear sweep in progress.
- Q  output  32*N  flat register contents; entry k occupies bits [k*N +: N].

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - All 32 entries = 0; Q = 0.
  - State = IDLE; sweep counter = 0; Busy = 0.
  - WrReady = 1 once Rst_n is high (unless ClrReq=1).
  - Reset asserted mid-sweep aborts the sweep immediately.
- States: IDLE, CLEAR.
- IDLE:
  - WrReady = ~ClrReq (combinational); Busy = 0.
  - Accepted write (WrEn & WrReady): entry[WrAddr] <= WrData at the next rising edge; new value is visible on Q the cycle after acceptance (latency 1).
  - Only the addressed entry changes; all other entries hold.
  - WrEn=0: no entry changes.
- ZERO_R0=1:
  - Write to address 0 is accepted (WrReady follows the normal rule) but entry 0 stays 0.
  - Q[N-1:0] is always 0.
- IDLE & ClrReq=1 -> CLEAR, counter <= 0.
  - ClrReq has priority over WrEn in the same cycle: WrReady=0, so that write is not accepted and the source must hold it.
- CLEAR:
  - Busy=1, WrReady=0, and WrEn is ignored.
  - Each cycle: entry[counter] <= 0, counter <= counter+1.
  - On the cycle counter==31, entry 31 is cleared and the state returns to IDLE with counter <= 0.
  - The sweep takes exactly 32 cycles; Busy is high for 32 consecutive cycles.
  - Entries not yet swept keep their old values until reached, so partial clear is visible on Q during the sweep.
  - ClrReq during CLEAR is ignored; it neither restarts nor extends the sweep.
  - The cycle after returning to IDLE, writes and a new ClrReq are accepted normally.
- Counter is 5 bits and wraps 31 -> 0 only at the CLEAR -> IDLE transition.
- Q is driven directly from the entry flops; there is no combinational path from WrData to Q (no write-through bypass).
- With ZERO_R0=1, entry 0 is not a flop, or is a flop held at constant 0; either is acceptable as long as Q[N-1:0] = 0 always.

Test Plan:
- Reset then idle: Rst_n low 3 cycles, release -> Q=0, WrReady=1, Busy=0.
- Write each address 1..31 with data 32'hA5000000+k, one per cycle -> each entry k reads 32'hA5000000+k one cycle after its write; all other entries unchanged.
- Write address 0 with 32'hFFFFFFFF, ZERO_R0=1 -> WrReady=1, Q[31:0] stays 0. Repeat with ZERO_R0=0 -> entry 0 = 32'hFFFFFFFF.
- Fill all entries with nonzero values, then pulse ClrReq together with WrEn (addr 5, 32'h12345678):
  - WrReady=0 that cycle, and the write is not performed.
  - Busy high exactly 32 cycles; entry k reads 0 from cycle k+1 after entry into CLEAR.
  - Second ClrReq at sweep cycle 10 is ignored.
  - WrReady=1 on the first cycle back in IDLE.
- WrEn held high throughout a sweep with addr 7, data 32'h0BADF00D -> entry 7 stays 0 until the sweep ends; the write is then accepted on the first IDLE cycle and entry 7 = 32'h0BADF00D one cycle later.
- Assert Rst_n low asynchronously at sweep cycle 15 -> Busy=0 and Q=0 immediately, without waiting for a clock edge; after release, state is IDLE and a write to addr 3 succeeds.

Source files
------------

// File: rtl/regfile_write_bank.sv
// Write side and storage of the 32-entry register file.
// Adds a write handshake and a 32-cycle sequenced clear-all sweep.
module regfile_write_bank #(
   parameter int N       = 32,
   parameter int ZERO_R0 = 1
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          WrEn,
   input  logic [4:0]    WrAddr,
   input  logic [N-1:0]  WrData,
   output logic          WrReady,
   input  logic          ClrReq,
   output logic          Busy,
   output logic [32*N-1:0] Q
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t       state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [N-1:0] ent_q [32];

   logic         we;
   logic [4:0]   wa;
   logic [N-1:0] wd;
   logic         wa_ok;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      WrReady = 1'b0;
      Busy    = 1'b0;
      we      = 1'b0;
      wa      = WrAddr;
      wd      = WrData;
      unique case (state_q)
         IDLE: begin
            WrReady = ~ClrReq;
            if (ClrReq) begin
               state_d = CLEAR;
               cnt_d   = 5'd0;
            end else if (WrEn) begin
               we = 1'b1;
            end
         end
         CLEAR: begin
            Busy  = 1'b1;
            we    = 1'b1;
            wa    = cnt_q;
            wd    = '0;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 5'd0;
         end
      endcase
   end

   // Entry 0 stays a flop but never takes a write when hardwired to zero
   assign wa_ok = !((ZERO_R0 != 0) && (wa == 5'd0));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int k = 0; k < 32; k++) begin
            ent_q[k] <= '0;
         end
      end else if (we && wa_ok) begin
         ent_q[wa] <= wd;
      end
   end

   for (genvar g = 0; g < 32; g++) begin : g_q
      assign Q[g*N +: N] = ent_q[g];
   end

endmodule
